apb_slave_mem: RTL

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

---
 rtl/apb_slave_mem.sv | 115 +++++++++++
 1 files changed

// File: rtl/apb_slave_mem.sv
// APB byte-wide scratch memory; optional wait states compiled in with APB_MEM_WAIT_EN.
// Latency: pready rises WAIT_CYCLES+1 cycles after penable (1 cycle without APB_MEM_WAIT_EN).
// Backpressure: pready stays low through wait states; DONE lasts one cycle and each transfer needs a fresh setup.
module apb_slave_mem #(
  parameter int         DEPTH       = 256,
  parameter logic [3:0] WAIT_CYCLES = 4'd2
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic [1:0] state
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            complete;
  logic            cnt_zero;
  logic            in_range;
  logic [AW-1:0]   idx;
  logic [7:0]      mem [DEPTH];

  assign in_range = ({1'b0, paddr} < DEPTH_W);
  assign idx      = paddr[AW-1:0];
  assign state    = state_q;

`ifdef APB_MEM_WAIT_EN
  logic [3:0] cnt;

  assign cnt_zero = (cnt == 4'd0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= 4'd0;
    end else if (state_q == IDLE && psel && !penable) begin
      cnt <= WAIT_CYCLES;
    end else if (state_q == BUSY && psel && !cnt_zero) begin
      cnt <= cnt - 4'd1;
    end
  end
`else
  assign cnt_zero = 1'b1;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A transfer only completes from BUSY, so an access phase seen in IDLE is dropped.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_zero && penable) begin
          state_d  = DONE;
          complete = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= 8'h00;
    end else begin
      pready  <= complete;
      pslverr <= complete && !in_range;
      if (complete && !pwrite) begin
        prdata <= in_range ? mem[idx] : 8'h00;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (complete && pwrite && in_range) begin
      mem[idx] <= pwdata;
    end
  end

endmodule
